rob_mc: RTL and testbench
=========================

Name: rob_mc

Overview:
- Parametrised next-generation reorder buffer with depth, data width and completion-port count as parameters.
- Unlike the previous ROB, it owns its own tail pointer and has a commit valid/ready handshake, precise exception flush, external flush and pending-aware operand bypass.
- Sits between decode/issue (allocation), the execution units ALU/MUL/LSU (completion), and the register file / exception unit (commit).

Parameters:
- ROB_DEPTH, 16, number of entries; any value ≥2, need not be a power of two.
- IDX_W, $clog2(ROB_DEPTH), entry index width.
- DATA_W, 32, result/PC/address width.
- N_CPL, 3, number of completion ports.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_alloc_valid  in  1  decode requests an entry.
- in_alloc_pc  in  DATA_W  instruction PC.
- in_alloc_addr  in  DATA_W  faulting/miss address captured at allocation.
- in_alloc_rd  in  5  destination register.
- in_alloc_wb  in  1  instruction writes rd.
- in_alloc_type  in  3  instruction type.
- out_alloc_ready  out  1  = !out_full && !flush_now.
- out_alloc_idx  out  IDX_W  current tail; the index the next allocation receives.
- in_cpl_valid  in  N_CPL  per-port completion strobe.
- in_cpl_idx  in  N_CPL*IDX_W  per-port entry index.
- in_cpl_value  in  N_CPL*DATA_W  per-port result.
- in_cpl_exc  in  N_CPL*3  per-port exception cause (0 = none).
- out_commit_valid  out  1  head is committable with no exception.
- in_commit_ready  in  1  consumer accepts the commit or exception.
- out_commit_value  out  DATA_W  head value.
- out_commit_rd  out  5  head rd.
- out_commit_wb  out  1  head wb flag.
- out_commit_type  out  3  head type.
- out_exc_valid  out  1  head is complete with a nonzero exception.
- out_exc_cause  out  3  head exception cause.
- out_exc_pc  out  DATA_W  head PC.
- out_exc_addr  out  DATA_W  head captured address.
- in_flush  in  1  external flush (branch mispredict).
- out_full  out  1  count == ROB_DEPTH.
- out_empty  out  1  count == 0.
- in_rs1, in_rs2  in  5 each  bypass lookup registers.
- out_rs1_hit, out_rs2_hit  out  1 each  bypass value valid.
- out_rs1_pend, out_rs2_pend  out  1 each  youngest producer not yet complete.
- out_rs1_value, out_rs2_value  out  DATA_W each  bypass values.

Behaviour:
- State per entry: valid, complete, exc, value, pc, addr, rd, wb, type.
- Pointers and count: head, tail (IDX_W bits); count (IDX_W+1 bits).

Reset:
- All valid/complete bits cleared; head = tail = count = 0.
- Resulting outputs: out_empty=1, out_full=0, out_alloc_ready=1, out_alloc_idx=0.
- out_commit_valid=0, out_exc_valid=0, all hit/pend=0, all data outputs 0.
- Reset overrides every other input in the same cycle.

Allocation:
- Accepted when in_alloc_valid && out_alloc_ready.
- Writes the entry at tail with valid=1, complete=0, exc=0.
- tail advances by 1; at ROB_DEPTH-1 it wraps to 0.
- Accepted allocation is visible to the bypass search the next cycle.

Completion:
- Port i writes value, exc and complete=1 to in_cpl_idx[i] only if that entry is valid.
- A completion to an invalid entry is ignored.
- Several ports targeting the same index in one cycle: the highest port number wins.
- Completion is accepted regardless of commit stall.

Commit:
- out_commit_valid = valid[head] && complete[head] && exc[head]==0. It is combinational from head state.
- Commit outputs mirror the head entry and are 0 when the head is invalid.
- On out_commit_valid && in_commit_ready: clear the head entry, advance head (wrapping), decrement count.
- Simultaneous allocate and commit leaves count unchanged.
- A full ROB that commits re-opens allocation the next cycle; no same-cycle pass-through.

Exception:
- out_exc_valid = valid[head] && complete[head] && exc[head]!=0; out_commit_valid=0 in that case.
- On out_exc_valid && in_commit_ready: flush.

Flush (exception-accepted or in_flush):
- flush_now is combinational.
- Next cycle: all entries invalid, head = tail = count = 0.
- Allocations and completions in the flush cycle are discarded.

Bypass (rs1 and rs2 independent, combinational):
- rs==0 gives hit=0 and pend=0.
- Search from tail-1 backwards to head over valid entries with wb=1 and rd==rs; the youngest match decides.
- Youngest match complete with exc==0: hit=1, value=entry value.
- Youngest match incomplete or excepting: pend=1, hit=0.
- Older matches are never used.
- No match: hit=0, pend=0, value=0.

Optional Feature:
- Macro: ROB_MC_CPL_BYPASS_EN.
- Defined: the bypass also checks the completion ports in the current cycle.
- If the youngest matching entry is incomplete and a completion port with exc==0 targets it this cycle, the result is hit=1, pend=0, value=that port's value.
- Port priority is the same as for completion writes.
- Undefined: the bypass sees registered ROB state only, with a one-cycle gap after completion.

Test Plan:
1. Reset; fill with ROB_DEPTH=16 allocations without completion -> out_full=1 after the 16th, out_alloc_ready=0; the 17th request is not accepted and out_alloc_idx stays 0 (wrapped).
2. Allocate idx0..2 (rd=5,6,7); complete idx2 then idx0 via ports 2 and 0 -> only idx0 commits (value visible); idx1 blocks idx2 until it completes; in_commit_ready=0 holds the commit outputs stable.
3. Allocate rd=5 at idx0 and rd=5 at idx1; complete idx0 with 0xAA; query rs1=5 -> pend=1, hit=0; complete idx1 with 0xBB -> next cycle hit=1, value=0xBB; rs1=0 -> hit=0.
4. Complete head with exc=3, pc=0x40, addr=0x1000 -> out_exc_valid=1 with those values and out_commit_valid=0; assert in_commit_ready with a same-cycle allocation -> next cycle out_empty=1, out_alloc_idx=0, and the allocation is discarded.
5. Wrap: set head=tail=14, then allocate and commit continuously for 40 cycles -> indices wrap 15→0; count is constant; committed values are in order.
6. Ports 0 and 2 both complete idx3 in one cycle with 0x11 and 0x22 -> 0x22 stored; with ROB_MC_CPL_BYPASS_EN, a same-cycle rs lookup of idx3's rd gives hit=1, value=0x22.

Source files
------------

// File: rtl/rob_mc.sv
// rob_mc: parametrised reorder buffer with its own tail pointer, commit valid/ready handshake,
// precise exception flush, external flush and pending-aware operand bypass.
// Optional feature macro ROB_MC_CPL_BYPASS_EN: bypass also forwards same-cycle completion-port results.
module rob_mc #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = $clog2(ROB_DEPTH),
    parameter int DATA_W    = 32,
    parameter int N_CPL     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_alloc_valid,
    input  logic [DATA_W-1:0]       in_alloc_pc,
    input  logic [DATA_W-1:0]       in_alloc_addr,
    input  logic [4:0]              in_alloc_rd,
    input  logic                    in_alloc_wb,
    input  logic [2:0]              in_alloc_type,
    output logic                    out_alloc_ready,
    output logic [IDX_W-1:0]        out_alloc_idx,
    input  logic [N_CPL-1:0]        in_cpl_valid,
    input  logic [N_CPL*IDX_W-1:0]  in_cpl_idx,
    input  logic [N_CPL*DATA_W-1:0] in_cpl_value,
    input  logic [N_CPL*3-1:0]      in_cpl_exc,
    output logic                    out_commit_valid,
    input  logic                    in_commit_ready,
    output logic [DATA_W-1:0]       out_commit_value,
    output logic [4:0]              out_commit_rd,
    output logic                    out_commit_wb,
    output logic [2:0]              out_commit_type,
    output logic                    out_exc_valid,
    output logic [2:0]              out_exc_cause,
    output logic [DATA_W-1:0]       out_exc_pc,
    output logic [DATA_W-1:0]       out_exc_addr,
    input  logic                    in_flush,
    output logic                    out_full,
    output logic                    out_empty,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    output logic                    out_rs1_hit,
    output logic                    out_rs2_hit,
    output logic                    out_rs1_pend,
    output logic                    out_rs2_pend,
    output logic [DATA_W-1:0]       out_rs1_value,
    output logic [DATA_W-1:0]       out_rs2_value
);

    localparam logic [IDX_W:0]   DEPTH_C   = (IDX_W+1)'(ROB_DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE_C = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] LAST_C    = IDX_W'(ROB_DEPTH - 1);

    typedef struct packed {
        logic              hit;
        logic              pend;
        logic [DATA_W-1:0] value;
    } byp_t;

    logic              valid_r    [ROB_DEPTH];
    logic              complete_r [ROB_DEPTH];
    logic [2:0]        exc_r      [ROB_DEPTH];
    logic [DATA_W-1:0] value_r    [ROB_DEPTH];
    logic [DATA_W-1:0] pc_r       [ROB_DEPTH];
    logic [DATA_W-1:0] addr_r     [ROB_DEPTH];
    logic [4:0]        rd_r       [ROB_DEPTH];
    logic              wb_r       [ROB_DEPTH];
    logic [2:0]        type_r     [ROB_DEPTH];

    logic [IDX_W-1:0]  head_r;
    logic [IDX_W-1:0]  tail_r;
    logic [IDX_W:0]    count_r;

    logic              head_valid_s;
    logic              commit_valid_s;
    logic              exc_valid_s;
    logic              commit_fire_s;
    logic              flush_now_s;
    logic              full_s;
    logic              alloc_ready_s;
    logic              alloc_fire_s;
    logic [IDX_W-1:0]  cpl_idx_s   [N_CPL];
    logic [DATA_W-1:0] cpl_value_s [N_CPL];
    logic [2:0]        cpl_exc_s   [N_CPL];
    logic              cpl_ok_s    [N_CPL];
    byp_t              rs1_byp_s;
    byp_t              rs2_byp_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == LAST_C) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    // Walks the live window oldest to youngest so the last match seen is the youngest producer.
    function automatic byp_t lookup(input logic [4:0] rs);
        byp_t             res;
        logic             found;
        logic [IDX_W-1:0] pos;
        logic [IDX_W-1:0] match;
        logic [IDX_W:0]   sum;
        logic             cpl_hit;
        logic [2:0]       cpl_exc;
        logic [DATA_W-1:0] cpl_val;
        res     = '0;
        found   = 1'b0;
        match   = {IDX_W{1'b0}};
        cpl_hit = 1'b0;
        cpl_exc = 3'd0;
        cpl_val = {DATA_W{1'b0}};
        for (int k = 0; k < ROB_DEPTH; k++) begin
            sum = {1'b0, head_r} + (IDX_W+1)'(k);
            if (sum >= DEPTH_C) begin
                sum = sum - DEPTH_C;
            end else begin
                sum = sum;
            end
            pos = sum[IDX_W-1:0];
            if (valid_r[pos] && wb_r[pos] && (rd_r[pos] == rs)) begin
                found = 1'b1;
                match = pos;
            end else begin
                found = found;
            end
        end
        for (int p = 0; p < N_CPL; p++) begin
            if (in_cpl_valid[p] && (cpl_idx_s[p] == match)) begin
                cpl_hit = 1'b1;
                cpl_exc = cpl_exc_s[p];
                cpl_val = cpl_value_s[p];
            end else begin
                cpl_hit = cpl_hit;
            end
        end
        if ((rs == 5'd0) || !found) begin
            res = '0;
        end else if (complete_r[match] && (exc_r[match] == 3'd0)) begin
            res.hit   = 1'b1;
            res.value = value_r[match];
        end else begin
`ifdef ROB_MC_CPL_BYPASS_EN
            if (!complete_r[match] && cpl_hit && (cpl_exc == 3'd0)) begin
                res.hit   = 1'b1;
                res.value = cpl_val;
            end else begin
                res.pend  = 1'b1;
            end
`else
            res.pend = 1'b1;
`endif
        end
        return res;
    endfunction

    // Head status, handshake fires and flush decision.
    always_comb begin
        head_valid_s   = valid_r[head_r];
        commit_valid_s = head_valid_s && complete_r[head_r] && (exc_r[head_r] == 3'd0);
        exc_valid_s    = head_valid_s && complete_r[head_r] && (exc_r[head_r] != 3'd0);
        commit_fire_s  = commit_valid_s && in_commit_ready;
        flush_now_s    = in_flush || (exc_valid_s && in_commit_ready);
        full_s         = (count_r == DEPTH_C);
        alloc_ready_s  = !full_s && !flush_now_s;
        alloc_fire_s   = in_alloc_valid && alloc_ready_s;
    end

    // Unpack completion ports and qualify each against a live, in-range entry.
    always_comb begin
        for (int p = 0; p < N_CPL; p++) begin
            cpl_idx_s[p]   = in_cpl_idx[p*IDX_W +: IDX_W];
            cpl_value_s[p] = in_cpl_value[p*DATA_W +: DATA_W];
            cpl_exc_s[p]   = in_cpl_exc[p*3 +: 3];
            cpl_ok_s[p]    = in_cpl_valid[p] && ({1'b0, cpl_idx_s[p]} < DEPTH_C) && valid_r[cpl_idx_s[p]];
        end
    end

    // Entry storage and pointers; later ports overwrite earlier ones, commit clear overrides completion.
    always_ff @(posedge clk) begin
        if (reset || flush_now_s) begin
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_r[i]    <= 1'b0;
                complete_r[i] <= 1'b0;
                exc_r[i]      <= 3'd0;
            end
        end else begin
            for (int p = 0; p < N_CPL; p++) begin
                if (cpl_ok_s[p]) begin
                    value_r[cpl_idx_s[p]]    <= cpl_value_s[p];
                    exc_r[cpl_idx_s[p]]      <= cpl_exc_s[p];
                    complete_r[cpl_idx_s[p]] <= 1'b1;
                end
            end
            if (commit_fire_s) begin
                valid_r[head_r]    <= 1'b0;
                complete_r[head_r] <= 1'b0;
                head_r             <= next_idx(head_r);
            end
            if (alloc_fire_s) begin
                valid_r[tail_r]    <= 1'b1;
                complete_r[tail_r] <= 1'b0;
                exc_r[tail_r]      <= 3'd0;
                value_r[tail_r]    <= {DATA_W{1'b0}};
                pc_r[tail_r]       <= in_alloc_pc;
                addr_r[tail_r]     <= in_alloc_addr;
                rd_r[tail_r]       <= in_alloc_rd;
                wb_r[tail_r]       <= in_alloc_wb;
                type_r[tail_r]     <= in_alloc_type;
                tail_r             <= next_idx(tail_r);
            end
            if (alloc_fire_s && !commit_fire_s) begin
                count_r <= count_r + CNT_ONE_C;
            end else if (!alloc_fire_s && commit_fire_s) begin
                count_r <= count_r - CNT_ONE_C;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Head mirror for commit and exception consumers; zero when the head slot is empty.
    always_comb begin
        out_commit_valid = commit_valid_s;
        out_exc_valid    = exc_valid_s;
        if (head_valid_s) begin
            out_commit_value = value_r[head_r];
            out_commit_rd    = rd_r[head_r];
            out_commit_wb    = wb_r[head_r];
            out_commit_type  = type_r[head_r];
            out_exc_cause    = exc_r[head_r];
            out_exc_pc       = pc_r[head_r];
            out_exc_addr     = addr_r[head_r];
        end else begin
            out_commit_value = {DATA_W{1'b0}};
            out_commit_rd    = 5'd0;
            out_commit_wb    = 1'b0;
            out_commit_type  = 3'd0;
            out_exc_cause    = 3'd0;
            out_exc_pc       = {DATA_W{1'b0}};
            out_exc_addr     = {DATA_W{1'b0}};
        end
    end

    // Operand bypass for both source registers.
    always_comb begin
        rs1_byp_s     = lookup(in_rs1);
        rs2_byp_s     = lookup(in_rs2);
        out_rs1_hit   = rs1_byp_s.hit;
        out_rs1_pend  = rs1_byp_s.pend;
        out_rs1_value = rs1_byp_s.value;
        out_rs2_hit   = rs2_byp_s.hit;
        out_rs2_pend  = rs2_byp_s.pend;
        out_rs2_value = rs2_byp_s.value;
    end

    // Status outputs.
    always_comb begin
        out_alloc_ready = alloc_ready_s;
        out_alloc_idx   = tail_r;
        out_full        = full_s;
        out_empty       = (count_r == {(IDX_W+1){1'b0}});
    end

endmodule

// File: tb/tb_rob_mc.sv
// Self-checking bench for rob_mc: commit scoreboard plus directed checks of allocation, bypass,
// exception/external flush, pointer wrap and completion-port priority.
module tb_rob_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_alloc_valid;
    logic [31:0] in_alloc_pc;
    logic [31:0] in_alloc_addr;
    logic [4:0]  in_alloc_rd;
    logic        in_alloc_wb;
    logic [2:0]  in_alloc_type;
    logic        out_alloc_ready;
    logic [3:0]  out_alloc_idx;
    logic [2:0]  in_cpl_valid;
    logic [11:0] in_cpl_idx;
    logic [95:0] in_cpl_value;
    logic [8:0]  in_cpl_exc;
    logic        out_commit_valid;
    logic        in_commit_ready;
    logic [31:0] out_commit_value;
    logic [4:0]  out_commit_rd;
    logic        out_commit_wb;
    logic [2:0]  out_commit_type;
    logic        out_exc_valid;
    logic [2:0]  out_exc_cause;
    logic [31:0] out_exc_pc;
    logic [31:0] out_exc_addr;
    logic        in_flush;
    logic        out_full;
    logic        out_empty;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_rs1_hit;
    logic        out_rs2_hit;
    logic        out_rs1_pend;
    logic        out_rs2_pend;
    logic [31:0] out_rs1_value;
    logic [31:0] out_rs2_value;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q [$];

    rob_mc dut (
        .clk(clk), .reset(reset),
        .in_alloc_valid(in_alloc_valid), .in_alloc_pc(in_alloc_pc), .in_alloc_addr(in_alloc_addr),
        .in_alloc_rd(in_alloc_rd), .in_alloc_wb(in_alloc_wb), .in_alloc_type(in_alloc_type),
        .out_alloc_ready(out_alloc_ready), .out_alloc_idx(out_alloc_idx),
        .in_cpl_valid(in_cpl_valid), .in_cpl_idx(in_cpl_idx), .in_cpl_value(in_cpl_value),
        .in_cpl_exc(in_cpl_exc),
        .out_commit_valid(out_commit_valid), .in_commit_ready(in_commit_ready),
        .out_commit_value(out_commit_value), .out_commit_rd(out_commit_rd),
        .out_commit_wb(out_commit_wb), .out_commit_type(out_commit_type),
        .out_exc_valid(out_exc_valid), .out_exc_cause(out_exc_cause),
        .out_exc_pc(out_exc_pc), .out_exc_addr(out_exc_addr),
        .in_flush(in_flush), .out_full(out_full), .out_empty(out_empty),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_rs1_hit(out_rs1_hit), .out_rs2_hit(out_rs2_hit),
        .out_rs1_pend(out_rs1_pend), .out_rs2_pend(out_rs2_pend),
        .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change only at posedge+1; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_alloc_valid = 1'b0; in_alloc_pc = 32'd0; in_alloc_addr = 32'd0;
        in_alloc_rd = 5'd0; in_alloc_wb = 1'b0; in_alloc_type = 3'd0;
        in_cpl_valid = 3'd0; in_cpl_idx = 12'd0; in_cpl_value = 96'd0; in_cpl_exc = 9'd0;
        in_commit_ready = 1'b0; in_flush = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_alloc(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] addr,
                             input logic push, input logic [31:0] val);
        in_alloc_valid = 1'b1; in_alloc_rd = rd; in_alloc_wb = 1'b1;
        in_alloc_pc = pc; in_alloc_addr = addr; in_alloc_type = 3'd1;
        if (push) exp_q.push_back(val);
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] addr,
                         input logic push, input logic [31:0] val);
        set_alloc(rd, pc, addr, push, val);
        tick();
        in_alloc_valid = 1'b0;
    endtask

    task automatic set_cpl(input int port, input logic [3:0] idx, input logic [31:0] val, input logic [2:0] exc);
        in_cpl_valid[port] = 1'b1;
        in_cpl_idx[port*4 +: 4] = idx;
        in_cpl_value[port*32 +: 32] = val;
        in_cpl_exc[port*3 +: 3] = exc;
    endtask

    task automatic complete(input int port, input logic [3:0] idx, input logic [31:0] val, input logic [2:0] exc);
        set_cpl(port, idx, val, exc);
        tick();
        in_cpl_valid = 3'd0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        in_commit_ready = 1'b1;
        while (!out_empty && n < bound) begin
            tick();
            n++;
        end
        check("drain_empty", {31'd0, out_empty}, 32'd1);
        in_commit_ready = 1'b0;
    endtask

    // Scoreboard: every accepted commit must match the oldest expected value.
    always @(negedge clk) begin
        if (!reset && out_commit_valid && in_commit_ready) begin
            check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("commit_value", out_commit_value, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_tail;
        logic [3:0]  prev_idx;
        logic [31:0] prev_val;
        logic [31:0] val;

        // Reset state and fill to full.
        do_reset();
        @(negedge clk);
        check("rst_empty", {31'd0, out_empty}, 32'd1);
        check("rst_full", {31'd0, out_full}, 32'd0);
        check("rst_ready", {31'd0, out_alloc_ready}, 32'd1);
        check("rst_idx", {28'd0, out_alloc_idx}, 32'd0);
        check("rst_cvalid", {31'd0, out_commit_valid}, 32'd0);
        check("rst_evalid", {31'd0, out_exc_valid}, 32'd0);
        check("rst_cvalue", out_commit_value, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) alloc(5'd1, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("fill_full", {31'd0, out_full}, 32'd1);
        check("fill_ready", {31'd0, out_alloc_ready}, 32'd0);
        check("fill_idx", {28'd0, out_alloc_idx}, 32'd0);
        tick();
        alloc(5'd1, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("over_full", {31'd0, out_full}, 32'd1);
        check("over_idx", {28'd0, out_alloc_idx}, 32'd0);
        tick();

        // In-order commit with a blocking incomplete entry.
        do_reset();
        alloc(5'd5, 32'h0, 32'h0, 1'b1, 32'h100);
        alloc(5'd6, 32'h4, 32'h0, 1'b1, 32'h101);
        alloc(5'd7, 32'h8, 32'h0, 1'b1, 32'h102);
        complete(2, 4'd2, 32'h102, 3'd0);
        complete(0, 4'd0, 32'h100, 3'd0);
        @(negedge clk);
        check("c_valid", {31'd0, out_commit_valid}, 32'd1);
        check("c_value", out_commit_value, 32'h100);
        check("c_rd", {27'd0, out_commit_rd}, 32'd5);
        tick();
        @(negedge clk);
        check("c_hold_valid", {31'd0, out_commit_valid}, 32'd1);
        check("c_hold_value", out_commit_value, 32'h100);
        tick();
        in_commit_ready = 1'b1;
        tick();
        @(negedge clk);
        check("c_blocked", {31'd0, out_commit_valid}, 32'd0);
        check("c_not_empty", {31'd0, out_empty}, 32'd0);
        tick();
        complete(1, 4'd1, 32'h101, 3'd0);
        drain(10);

        // Bypass: youngest producer decides.
        do_reset();
        alloc(5'd5, 32'h0, 32'h0, 1'b1, 32'hAA);
        alloc(5'd5, 32'h4, 32'h0, 1'b1, 32'hBB);
        complete(0, 4'd0, 32'hAA, 3'd0);
        in_rs1 = 5'd5;
        in_rs2 = 5'd6;
        @(negedge clk);
        check("byp_pend", {31'd0, out_rs1_pend}, 32'd1);
        check("byp_nohit", {31'd0, out_rs1_hit}, 32'd0);
        check("byp_nomatch", {30'd0, out_rs2_hit, out_rs2_pend}, 32'd0);
        tick();
        set_cpl(1, 4'd1, 32'hBB, 3'd0);
        @(negedge clk);
`ifdef ROB_MC_CPL_BYPASS_EN
        check("byp_fwd_hit", {31'd0, out_rs1_hit}, 32'd1);
        check("byp_fwd_value", out_rs1_value, 32'hBB);
`else
        check("byp_gap_pend", {31'd0, out_rs1_pend}, 32'd1);
`endif
        tick();
        in_cpl_valid = 3'd0;
        @(negedge clk);
        check("byp_hit", {31'd0, out_rs1_hit}, 32'd1);
        check("byp_value", out_rs1_value, 32'hBB);
        check("byp_pend0", {31'd0, out_rs1_pend}, 32'd0);
        tick();
        in_rs1 = 5'd0;
        @(negedge clk);
        check("byp_r0", {30'd0, out_rs1_hit, out_rs1_pend}, 32'd0);
        tick();
        drain(10);

        // Precise exception flush discards a same-cycle allocation; then external flush.
        do_reset();
        alloc(5'd4, 32'h40, 32'h1000, 1'b0, 32'd0);
        complete(1, 4'd0, 32'h0, 3'd3);
        @(negedge clk);
        check("exc_valid", {31'd0, out_exc_valid}, 32'd1);
        check("exc_cause", {29'd0, out_exc_cause}, 32'd3);
        check("exc_pc", out_exc_pc, 32'h40);
        check("exc_addr", out_exc_addr, 32'h1000);
        check("exc_cvalid", {31'd0, out_commit_valid}, 32'd0);
        tick();
        in_commit_ready = 1'b1;
        set_alloc(5'd8, 32'h44, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        check("exc_alloc_blk", {31'd0, out_alloc_ready}, 32'd0);
        tick();
        in_alloc_valid = 1'b0;
        in_commit_ready = 1'b0;
        @(negedge clk);
        check("exc_empty", {31'd0, out_empty}, 32'd1);
        check("exc_idx", {28'd0, out_alloc_idx}, 32'd0);
        check("exc_cleared", {31'd0, out_exc_valid}, 32'd0);
        tick();
        alloc(5'd2, 32'h0, 32'h0, 1'b0, 32'd0);
        alloc(5'd3, 32'h0, 32'h0, 1'b0, 32'd0);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        @(negedge clk);
        check("flush_empty", {31'd0, out_empty}, 32'd1);
        check("flush_idx", {28'd0, out_alloc_idx}, 32'd0);
        tick();

        // Pointer wrap under continuous allocate+commit.
        do_reset();
        for (int i = 0; i < 14; i++) alloc(5'd1, 32'h0, 32'h0, 1'b1, 32'h3000 + i);
        for (int i = 0; i < 14; i++) complete(i % 3, 4'(i), 32'h3000 + i, 3'd0);
        drain(30);
        @(negedge clk);
        check("wrap_start", {28'd0, out_alloc_idx}, 32'd14);
        tick();
        alloc(5'd1, 32'h0, 32'h0, 1'b1, 32'h5000);
        alloc(5'd1, 32'h0, 32'h0, 1'b1, 32'h5001);
        complete(0, 4'd14, 32'h5000, 3'd0);
        exp_tail = 4'd0;
        prev_idx = 4'd15;
        prev_val = 32'h5001;
        for (int k = 0; k < 40; k++) begin
            val = 32'h5002 + k;
            set_alloc(5'd1, 32'h0, 32'h0, 1'b1, val);
            set_cpl(k % 3, prev_idx, prev_val, 3'd0);
            in_commit_ready = 1'b1;
            @(negedge clk);
            check("wrap_idx", {28'd0, out_alloc_idx}, {28'd0, exp_tail});
            check("wrap_cvalid", {31'd0, out_commit_valid}, 32'd1);
            check("wrap_notfull", {31'd0, out_full}, 32'd0);
            tick();
            in_alloc_valid = 1'b0;
            in_cpl_valid = 3'd0;
            prev_idx = exp_tail;
            prev_val = val;
            exp_tail = (exp_tail == 4'd15) ? 4'd0 : exp_tail + 4'd1;
        end
        complete(0, prev_idx, prev_val, 3'd0);
        drain(10);

        // Highest completion port wins on a shared index.
        do_reset();
        alloc(5'd1, 32'h0, 32'h0, 1'b1, 32'h61);
        alloc(5'd2, 32'h0, 32'h0, 1'b1, 32'h62);
        alloc(5'd3, 32'h0, 32'h0, 1'b1, 32'h63);
        alloc(5'd9, 32'h0, 32'h0, 1'b1, 32'h22);
        complete(0, 4'd0, 32'h61, 3'd0);
        complete(1, 4'd1, 32'h62, 3'd0);
        complete(2, 4'd2, 32'h63, 3'd0);
        set_cpl(0, 4'd3, 32'h11, 3'd0);
        set_cpl(2, 4'd3, 32'h22, 3'd0);
        in_rs2 = 5'd9;
        @(negedge clk);
`ifdef ROB_MC_CPL_BYPASS_EN
        check("prio_fwd_hit", {31'd0, out_rs2_hit}, 32'd1);
        check("prio_fwd_value", out_rs2_value, 32'h22);
`else
        check("prio_gap_pend", {31'd0, out_rs2_pend}, 32'd1);
`endif
        tick();
        in_cpl_valid = 3'd0;
        @(negedge clk);
        check("prio_hit", {31'd0, out_rs2_hit}, 32'd1);
        check("prio_value", out_rs2_value, 32'h22);
        tick();
        drain(10);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
